// File: rtl/lc2k_pkg.sv
// Shared LC2K definitions: opcodes, FSM states, instruction field positions
// and the offset sign-extension helper.
package lc2k_pkg;

   typedef enum logic [2:0] {
      ADD  = 3'd0,
      NOR  = 3'd1,
      LW   = 3'd2,
      SW   = 3'd3,
      BEQ  = 3'd4,
      JALR = 3'd5,
      HALT = 3'd6,
      NOOP = 3'd7
   } opcode_e;

   typedef enum logic [2:0] {
      S_FETCH,
      S_DECODE,
      S_EXEC,
      S_MEM,
      S_WB,
      S_HALTED
   } state_e;

   // Only bits [24:0] of an instruction word carry meaning.
   localparam int IR_W   = 25;
   localparam int OPC_LO = 22;
   localparam int RA_LO  = 19;
   localparam int RB_LO  = 16;
   localparam int DST_LO = 0;
   localparam int OFF_W  = 16;

   function automatic logic [63:0] sext16(input logic [OFF_W-1:0] v);
      return {{(64-OFF_W){v[OFF_W-1]}}, v};
   endfunction

endpackage

// File: rtl/lc2k_regfile.sv
// Eight-entry register file: two async read ports, a debug read port and
// one synchronous write port; entry 0 optionally hard-wired to zero.
module lc2k_regfile #(
   parameter int DATA_W  = 32,
   parameter int R0_ZERO = 1
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [2:0]        ra_i,
   input  logic [2:0]        rb_i,
   input  logic [2:0]        dbg_sel_i,
   output logic [DATA_W-1:0] ra_data_o,
   output logic [DATA_W-1:0] rb_data_o,
   output logic [DATA_W-1:0] dbg_data_o,
   input  logic              we_i,
   input  logic [2:0]        waddr_i,
   input  logic [DATA_W-1:0] wdata_i
);

   logic [7:0][DATA_W-1:0] regs_q;
   logic                   wr_blocked;

   assign wr_blocked = (R0_ZERO != 0) && (waddr_i == 3'd0);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         regs_q <= '0;
      end else if (we_i && !wr_blocked) begin
         regs_q[waddr_i] <= wdata_i;
      end
   end

   assign ra_data_o  = ((R0_ZERO != 0) && ra_i == 3'd0)      ? '0 : regs_q[ra_i];
   assign rb_data_o  = ((R0_ZERO != 0) && rb_i == 3'd0)      ? '0 : regs_q[rb_i];
   assign dbg_data_o = ((R0_ZERO != 0) && dbg_sel_i == 3'd0) ? '0 : regs_q[dbg_sel_i];

endmodule

// File: rtl/lc2k_multicycle_core.sv
// Multi-cycle LC2K core over one req/ready memory port; FSM, PC, datapath
// latches and the saturating retire counter live here.
module lc2k_multicycle_core
   import lc2k_pkg::*;
#(
   parameter int          DATA_W   = 32,
   parameter int          ADDR_W   = 16,
   parameter int unsigned RESET_PC = 0,
   parameter int          R0_ZERO  = 1,
   parameter int          COUNT_W  = 32
) (
   input  logic               clk,
   input  logic               reset_n,
   output logic               mem_req,
   output logic               mem_we,
   output logic [ADDR_W-1:0]  mem_addr,
   output logic [DATA_W-1:0]  mem_wdata,
   input  logic               mem_ready,
   input  logic [DATA_W-1:0]  mem_rdata,
   output logic               halted,
   output logic [ADDR_W-1:0]  pc_out,
   output logic [COUNT_W-1:0] instr_count,
   input  logic [2:0]         dbg_sel,
   output logic [DATA_W-1:0]  dbg_data
);

   state_e              state_q, state_d;
   logic [ADDR_W-1:0]   pc_q, pc_d;
   logic [IR_W-1:0]     ir_q, ir_d;
   logic [DATA_W-1:0]   a_q, a_d, b_q, b_d, off_q, off_d;
   logic [DATA_W-1:0]   alu_q, alu_d, mdr_q, mdr_d;
   logic [COUNT_W-1:0]  cnt_q, cnt_d;

   opcode_e             op;
   logic [2:0]          ra, rb, dst;
   logic [DATA_W-1:0]   ra_data, rb_data;
   logic [ADDR_W-1:0]   pc_inc;
   logic                req, retire;
   logic                rf_we;
   logic [2:0]          rf_waddr;
   logic [DATA_W-1:0]   rf_wdata;

   assign op     = opcode_e'(ir_q[OPC_LO +: 3]);
   assign ra     = ir_q[RA_LO +: 3];
   assign rb     = ir_q[RB_LO +: 3];
   assign dst    = ir_q[DST_LO +: 3];
   assign pc_inc = pc_q + ADDR_W'(1);

   lc2k_regfile #(
      .DATA_W  (DATA_W),
      .R0_ZERO (R0_ZERO)
   ) u_rf (
      .clk        (clk),
      .reset_n    (reset_n),
      .ra_i       (ra),
      .rb_i       (rb),
      .dbg_sel_i  (dbg_sel),
      .ra_data_o  (ra_data),
      .rb_data_o  (rb_data),
      .dbg_data_o (dbg_data),
      .we_i       (rf_we),
      .waddr_i    (rf_waddr),
      .wdata_i    (rf_wdata)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_FETCH;
         pc_q    <= ADDR_W'(RESET_PC);
         ir_q    <= '0;
         a_q     <= '0;
         b_q     <= '0;
         off_q   <= '0;
         alu_q   <= '0;
         mdr_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         ir_q    <= ir_d;
         a_q     <= a_d;
         b_q     <= b_d;
         off_q   <= off_d;
         alu_q   <= alu_d;
         mdr_q   <= mdr_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      ir_d      = ir_q;
      a_d       = a_q;
      b_d       = b_q;
      off_d     = off_q;
      alu_d     = alu_q;
      mdr_d     = mdr_q;
      req       = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = pc_q;
      mem_wdata = b_q;
      rf_we     = 1'b0;
      rf_waddr  = dst;
      rf_wdata  = alu_q;
      retire    = 1'b0;

      case (state_q)
         S_FETCH: begin
            req = 1'b1;
            if (mem_ready) begin
               ir_d    = IR_W'(mem_rdata);
               state_d = S_DECODE;
            end
         end
         S_DECODE: begin
            a_d     = ra_data;
            b_d     = rb_data;
            off_d   = DATA_W'(sext16(ir_q[OFF_W-1:0]));
            state_d = S_EXEC;
         end
         S_EXEC: begin
            case (op)
               ADD: begin
                  alu_d   = a_q + b_q;
                  state_d = S_WB;
               end
               NOR: begin
                  alu_d   = ~(a_q | b_q);
                  state_d = S_WB;
               end
               LW, SW: begin
                  alu_d   = a_q + off_q;
                  state_d = S_MEM;
               end
               BEQ: begin
                  pc_d    = (a_q == b_q) ? pc_inc + ADDR_W'(off_q) : pc_inc;
                  retire  = 1'b1;
                  state_d = S_FETCH;
               end
               JALR: state_d = S_WB;
               HALT: begin
                  pc_d    = pc_inc;
                  retire  = 1'b1;
                  state_d = S_HALTED;
               end
               default: begin
                  pc_d    = pc_inc;
                  retire  = 1'b1;
                  state_d = S_FETCH;
               end
            endcase
         end
         S_MEM: begin
            // Address/data come from latches, so they hold across wait states.
            req      = 1'b1;
            mem_addr = ADDR_W'(alu_q);
            mem_we   = (op == SW);
            if (mem_ready) begin
               if (op == SW) begin
                  pc_d    = pc_inc;
                  retire  = 1'b1;
                  state_d = S_FETCH;
               end else begin
                  mdr_d   = mem_rdata;
                  state_d = S_WB;
               end
            end
         end
         S_WB: begin
            retire  = 1'b1;
            state_d = S_FETCH;
            pc_d    = pc_inc;
            case (op)
               ADD, NOR: rf_we = 1'b1;
               LW: begin
                  rf_we    = 1'b1;
                  rf_waddr = rb;
                  rf_wdata = mdr_q;
               end
               JALR: begin
                  // Target uses A latched in DECODE, i.e. before this write.
                  rf_we    = 1'b1;
                  rf_waddr = rb;
                  rf_wdata = DATA_W'(pc_inc);
                  pc_d     = ADDR_W'(a_q);
               end
               default: ;
            endcase
         end
         default: ;
      endcase

      cnt_d = (retire && !(&cnt_q)) ? cnt_q + COUNT_W'(1) : cnt_q;
   end

   // Gating with reset_n drops the request asynchronously on reset.
   assign mem_req     = req && reset_n;
   assign halted      = (state_q == S_HALTED);
   assign pc_out      = pc_q;
   assign instr_count = cnt_q;

endmodule
